// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load/store port.
//   - funct3 encodings for the supported access widths
//   - FSM state type of mem_stall_unit
//   - byte-strobe type for the memory request channel
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  typedef logic [3:0] strb_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane logic for one access.
// Ports:
//   i_funct3  : access width/sign encoding
//   i_addr_lo : byte offset within the 32-bit word
//   i_wdata   : right-aligned store data
//   i_rdata   : raw read word from memory
//   o_legal   : funct3 supported and address naturally aligned
//   o_strb    : byte strobes for the access width (caller masks for loads)
//   o_wdata   : store data replicated across all lanes
//   o_rdata   : selected byte/half/word, sign- or zero-extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal,
  output strb_t       o_strb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_legal = 1'b0;
    o_strb  = '0;
    o_wdata = i_wdata;
    o_rdata = '0;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        o_legal = 1'b1;
        o_strb  = strb_t'(4'b0001 << i_addr_lo);
        o_wdata = {4{i_wdata[7:0]}};
        // funct3[2] distinguishes the unsigned variants
        o_rdata = {{24{w_byte[7] & ~i_funct3[2]}}, w_byte};
      end
      F3_LH, F3_LHU: begin
        o_legal = ~i_addr_lo[0];
        o_strb  = strb_t'(4'b0011 << i_addr_lo);
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
      end
      F3_LW: begin
        o_legal = (i_addr_lo == 2'b00);
        o_strb  = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stall_unit.sv
// mem_stall_unit: MEM-stage load/store port for a variable-latency memory.
// Launches each access over a valid/ready request channel, waits for the
// response and holds mem_stall until the access completes.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   mem_*_MEM            : access from the EX/MEM register
//   mem_stall            : freeze request to pipeline control
//   mem_done             : one-cycle completion pulse, mem_rdata valid with it
//   mem_misalign         : one-cycle pulse, access rejected (alignment/funct3)
//   mem_timeout          : one-cycle pulse, no response within TIMEOUT_CYCLES
//   req_*                : request channel to the data memory
//   resp_valid/resp_rdata: response channel (also used as write-ack)
module mem_stall_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_access_MEM,
  input  logic        mem_we_MEM,
  input  logic [2:0]  mem_funct3_MEM,
  input  logic [31:0] mem_addr_MEM,
  input  logic [31:0] mem_wdata_MEM,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_misalign,
  output logic        mem_timeout,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output strb_t       req_strb,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  mem_state_e  r_state;
  mem_state_e  w_state_next;
  logic [15:0] r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_timeout;
  logic        r_skip_done;

  logic [15:0] w_cnt_inc;
  logic        w_cnt_expired;
  logic [2:0]  w_al_funct3;
  logic [1:0]  w_al_addr_lo;
  logic        w_legal;
  strb_t       w_lane_strb;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_start;

  assign w_cnt_inc     = r_cnt + 16'd1;
  assign w_cnt_expired = (w_cnt_inc == TIMEOUT_LIM);

  // In IDLE the legality check must see the live access; afterwards the
  // lane logic works from the latched copy so req_* stay stable.
  assign w_al_funct3  = (r_state == ST_IDLE) ? mem_funct3_MEM    : r_funct3;
  assign w_al_addr_lo = (r_state == ST_IDLE) ? mem_addr_MEM[1:0] : r_addr[1:0];

  // Gate with rst_n so the combinational IDLE outputs are also 0 in reset.
  assign w_start = mem_access_MEM & rst_n;

  mem_lane_align u_align (
    .i_funct3  (w_al_funct3),
    .i_addr_lo (w_al_addr_lo),
    .i_wdata   (r_wdata),
    .i_rdata   (resp_rdata),
    .o_legal   (w_legal),
    .o_strb    (w_lane_strb),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    mem_rdata    = '0;
    mem_misalign = 1'b0;
    mem_timeout  = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_strb     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_legal) begin
            mem_stall    = 1'b1;
            w_state_next = ST_REQ;
          end else begin
            mem_misalign = 1'b1;
            mem_done     = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        req_valid = 1'b1;
        req_we    = r_we;
        req_addr  = {r_addr[31:2], 2'b00};
        req_wdata = w_lane_wdata;
        req_strb  = r_we ? w_lane_strb : 4'b0000;
        if (req_ready) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (resp_valid || w_cnt_expired) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A rejected access already reported mem_done in its IDLE cycle.
        mem_done     = ~r_skip_done;
        mem_rdata    = r_rdata;
        mem_timeout  = r_timeout;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_timeout   <= 1'b0;
      r_skip_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (mem_access_MEM) begin
            r_we        <= mem_we_MEM;
            r_funct3    <= mem_funct3_MEM;
            r_addr      <= mem_addr_MEM;
            r_wdata     <= mem_wdata_MEM;
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
            r_skip_done <= ~w_legal;
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            r_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (resp_valid) begin
            r_rdata <= r_we ? 32'd0 : w_lane_rdata;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_expired) begin
              r_timeout <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_rdata     <= '0;
          r_timeout   <= 1'b0;
          r_skip_done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_unit.sv
module tb_mem_stall_unit;

  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_access_MEM;
  logic        mem_we_MEM;
  logic [2:0]  mem_funct3_MEM;
  logic [31:0] mem_addr_MEM;
  logic [31:0] mem_wdata_MEM;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_misalign;
  logic        mem_timeout;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  mem_stall_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_access_MEM (mem_access_MEM),
    .mem_we_MEM     (mem_we_MEM),
    .mem_funct3_MEM (mem_funct3_MEM),
    .mem_addr_MEM   (mem_addr_MEM),
    .mem_wdata_MEM  (mem_wdata_MEM),
    .mem_stall      (mem_stall),
    .mem_done       (mem_done),
    .mem_rdata      (mem_rdata),
    .mem_misalign   (mem_misalign),
    .mem_timeout    (mem_timeout),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_strb       (req_strb),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          rsp;
    logic [31:0] raw;
    logic        legal;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        to;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s act=%h exp=%h", tag, name, act, exp);
    end
  endtask

  // Reference: access outcome from the width/alignment/extension rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] raw,
                       output logic legal, output logic [3:0] strb,
                       output logic [31:0] wd, output logic [31:0] rd);
    int size;
    int ofs;
    longint v;
    longint half_range;
    bit sgn;
    ofs  = int'(addr % 4);
    size = 4;
    sgn  = 1'b0;
    legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd4: begin size = 1; end
      3'd1: begin size = 2; sgn = 1'b1; legal = (ofs % 2 == 0); end
      3'd5: begin size = 2; legal = (ofs % 2 == 0); end
      3'd2: begin size = 4; legal = (ofs == 0); end
      default: legal = 1'b0;
    endcase
    strb = we ? 4'(((1 << size) - 1) << ofs) : 4'd0;
    if (size == 1)      wd = wdata[7:0] * 32'h01010101;
    else if (size == 2) wd = wdata[15:0] * 32'h00010001;
    else                wd = wdata;
    rd = 32'd0;
    if (!we && legal) begin
      v = (longint'(raw) >> (8 * ofs)) % (64'sd1 << (8 * size));
      half_range = 64'sd1 << (8 * size - 1);
      if (sgn && v >= half_range) v = v - 2 * half_range;
      rd = 32'(v);
    end
  endtask

  task automatic idle_inputs();
    mem_access_MEM = 1'b0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
  endtask

  // One access, acting as the memory and checking every cycle.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdy, input int rsp, input logic [31:0] raw,
                           input logic legal, input logic [3:0] strb,
                           input logic [31:0] wd, input logic [31:0] rd, input logic to);
    bit gave;
    mem_access_MEM = 1'b1;
    mem_we_MEM     = we;
    mem_funct3_MEM = f3;
    mem_addr_MEM   = addr;
    mem_wdata_MEM  = wdata;
    req_ready      = 1'b0;
    resp_valid     = 1'($urandom_range(0, 1));
    resp_rdata     = $urandom;
    #1;
    chk(tag, "idle_stall", 32'(mem_stall), 32'(legal));
    chk(tag, "idle_done", 32'(mem_done), 32'(!legal));
    chk(tag, "idle_misalign", 32'(mem_misalign), 32'(!legal));
    chk(tag, "idle_rdata", mem_rdata, 32'd0);
    chk(tag, "idle_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk);
    if (!legal) begin
      idle_inputs();
      #1;
      chk(tag, "rej_done", 32'(mem_done), 32'd0);
      chk(tag, "rej_stall", 32'(mem_stall), 32'd0);
      chk(tag, "rej_misalign", 32'(mem_misalign), 32'd0);
      chk(tag, "rej_req_valid", 32'(req_valid), 32'd0);
      @(negedge clk);
      return;
    end
    for (int k = 0; k <= rdy; k++) begin
      req_ready  = (k == rdy);
      resp_valid = (k != rdy) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk(tag, "req_valid", 32'(req_valid), 32'd1);
      chk(tag, "req_stall", 32'(mem_stall), 32'd1);
      chk(tag, "req_addr", req_addr, addr & 32'hFFFF_FFFC);
      chk(tag, "req_we", 32'(req_we), 32'(we));
      chk(tag, "req_strb", 32'(req_strb), 32'(strb));
      if (we) chk(tag, "req_wdata", req_wdata, wd);
      @(negedge clk);
    end
    req_ready = 1'b0;
    gave = 1'b0;
    for (int w = 0; w < T; w++) begin
      resp_valid = (w == rsp);
      resp_rdata = raw;
      #1;
      chk(tag, "wait_stall", 32'(mem_stall), 32'd1);
      chk(tag, "wait_req_valid", 32'(req_valid), 32'd0);
      chk(tag, "wait_done", 32'(mem_done), 32'd0);
      chk(tag, "wait_timeout", 32'(mem_timeout), 32'd0);
      @(negedge clk);
      if (w == rsp) begin
        gave = 1'b1;
        break;
      end
    end
    mem_access_MEM = 1'b0;
    resp_valid     = 1'($urandom_range(0, 1));
    resp_rdata     = $urandom;
    #1;
    chk(tag, "done_done", 32'(mem_done), 32'd1);
    chk(tag, "done_stall", 32'(mem_stall), 32'd0);
    chk(tag, "done_rdata", mem_rdata, rd);
    chk(tag, "done_timeout", 32'(mem_timeout), 32'(to));
    chk(tag, "done_misalign", 32'(mem_misalign), 32'd0);
    chk(tag, "resp_given", 32'(gave), 32'(!to));
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic idle_stray(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      mem_access_MEM = 1'b0;
      resp_valid     = 1'b1;
      resp_rdata     = $urandom;
      #1;
      chk(tag, "stall", 32'(mem_stall), 32'd0);
      chk(tag, "done", 32'(mem_done), 32'd0);
      chk(tag, "timeout", 32'(mem_timeout), 32'd0);
      chk(tag, "req_valid", 32'(req_valid), 32'd0);
      @(negedge clk);
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_raw, e_wd, e_rd;
    logic        e_legal;
    logic [3:0]  e_strb;
    int          r_rdy, r_rsp;
    logic [2:0]  f3_pool [7];

    vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,         0, 1,  32'hDEADBEEF, 1'b1, 4'h0, 32'h0,         32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,         1, 0,  32'h80FF0000, 1'b1, 4'h0, 32'h0,         32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,         0, 2,  32'h80FF0000, 1'b1, 4'h0, 32'h0,         32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 3'd5, 32'h102, 32'h0,         1, 1,  32'h80FF0000, 1'b1, 4'h0, 32'h0,         32'h000080FF, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD,  2, 0,  32'h5A5A5A5A, 1'b1, 4'hC, 32'hABCDABCD, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 3'd2, 32'h101, 32'h0,         0, 0,  32'h0,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[6]  = '{1'b0, 3'd3, 32'h100, 32'h0,         0, 0,  32'h0,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[7]  = '{1'b0, 3'd2, 32'h300, 32'h0,         0, 99, 32'h0,        1'b1, 4'h0, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 3'd0, 32'h001, 32'h00000055,  0, 1,  32'h0,        1'b1, 4'h2, 32'h55555555, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 3'd1, 32'h101, 32'h0,         0, 0,  32'h0,        1'b0, 4'h0, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b0, 3'd1, 32'h002, 32'h0,         0, 3,  32'h80011234, 1'b1, 4'h0, 32'h0,         32'hFFFF8001, 1'b0};
    vecs[11] = '{1'b1, 3'd2, 32'h000, 32'hCAFEF00D,  1, 2,  32'h0,        1'b1, 4'hF, 32'hCAFEF00D, 32'h0,         1'b0};

    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    rst_n          = 1'b0;
    mem_access_MEM = 1'b1;
    mem_we_MEM     = 1'b0;
    mem_funct3_MEM = 3'd2;
    mem_addr_MEM   = 32'h100;
    mem_wdata_MEM  = 32'h0;
    req_ready      = 1'b1;
    resp_valid     = 1'b1;
    resp_rdata     = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", "stall", 32'(mem_stall), 32'd0);
    chk("reset", "done", 32'(mem_done), 32'd0);
    chk("reset", "req_valid", 32'(req_valid), 32'd0);
    chk("reset", "req_addr", req_addr, 32'd0);
    chk("reset", "rdata", mem_rdata, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].rdy, vecs[i].rsp, vecs[i].raw, vecs[i].legal, vecs[i].strb,
                vecs[i].wd, vecs[i].rd, vecs[i].to);
    end

    // Timeout followed by late responses while idle.
    do_access("timeout", 1'b1, 3'd2, 32'h500, 32'h11223344, 0, 99, 32'h0,
              1'b1, 4'hF, 32'h11223344, 32'h0, 1'b1);
    idle_stray("late_resp", 3);

    // Reset asserted while waiting for a response.
    mem_access_MEM = 1'b1;
    mem_we_MEM     = 1'b0;
    mem_funct3_MEM = 3'd2;
    mem_addr_MEM   = 32'h400;
    req_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    chk("rst_mid", "wait_stall", 32'(mem_stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "stall", 32'(mem_stall), 32'd0);
    chk("rst_mid", "done", 32'(mem_done), 32'd0);
    chk("rst_mid", "misalign", 32'(mem_misalign), 32'd0);
    chk("rst_mid", "timeout", 32'(mem_timeout), 32'd0);
    chk("rst_mid", "req_valid", 32'(req_valid), 32'd0);
    chk("rst_mid", "req_addr", req_addr, 32'd0);
    chk("rst_mid", "req_strb", 32'(req_strb), 32'd0);
    chk("rst_mid", "rdata", mem_rdata, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    idle_stray("stale_resp", 2);
    do_access("post_rst", 1'b0, 3'd2, 32'h404, 32'h0, 0, 1, 32'h0BADF00D,
              1'b1, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = f3_pool[$urandom_range(0, 6)];
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_raw   = $urandom;
      r_rdy   = $urandom_range(0, 3);
      r_rsp   = $urandom_range(0, 5);
      model(r_we, r_f3, r_addr, r_wdata, r_raw, e_legal, e_strb, e_wd, e_rd);
      if (r_rsp >= T) e_rd = 32'd0;
      do_access($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wdata, r_rdy, r_rsp, r_raw,
                e_legal, e_strb, e_wd, e_rd, e_legal && (r_rsp >= T));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stall_unit.md
Name: mem_stall_unit

Overview:
- Responder side of the pipeline's stall protocol: the MEM-stage load/store port for a variable-latency data memory.
- Launches each MEM-stage access over a valid/ready request channel, waits for the response, and holds a stall request to the pipeline until the access completes.
- Returns aligned, sign/zero-extended load data and error pulses.
- Sits between the EX/MEM pipeline register and the data-memory/cache; its stall output freezes PC, IF/ID, ID/EX and EX/MEM and inserts a bubble into MEM/WB.

Parameters:
TIMEOUT_CYCLES, 255, WAIT-state cycles without resp_valid before the access is abandoned with an error; range 1..65535.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
mem_access_MEM  input  1  MEM-stage instruction is a load or store
mem_we_MEM  input  1  1 = store, 0 = load
mem_funct3_MEM  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
mem_addr_MEM  input  32  byte address
mem_wdata_MEM  input  32  store data, right-aligned
mem_stall  output  1  freeze request to pipeline control
mem_done  output  1  one-cycle pulse: access completed this cycle
mem_rdata  output  32  extended load data, valid while mem_done=1
mem_misalign  output  1  one-cycle pulse: access not issued, misaligned or illegal funct3
mem_timeout  output  1  one-cycle pulse: response timeout
req_valid  output  1  memory request valid
req_ready  input  1  memory accepts request
req_we  output  1  request is a write
req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
req_wdata  output  32  lane-replicated write data
req_strb  output  4  byte write strobes (0000 for reads)
resp_valid  input  1  response or write-ack valid
resp_rdata  input  32  raw read word

Behaviour:
- Decision: clock and reset use the codebase's clk and rst_n names. There is one clock, and reset is asynchronous and active-low.
- Reset (async, any state): FSM to IDLE; timeout counter 0; all outputs 0, including req_*, mem_rdata and the pulses.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_access_MEM=1 and the access is legal, mem_stall=1 combinationally in the same cycle.
  - Address, data, we and funct3 are latched; next state is REQ.
  - If mem_access_MEM=1 and the access is illegal, no request is issued. Illegal means H with addr[0]≠0, W with addr[1:0]≠0, or funct3 ∉ {000,001,010,100,101}.
  - For an illegal access, mem_misalign=1 and mem_done=1 for that cycle, with mem_stall=0 and mem_rdata=0. Next state is DONE.
- REQ:
  - req_valid=1; req_* are driven from latched values and held stable until the handshake.
  - The request transfers on the edge where req_valid & req_ready; next state is WAIT and the counter clears.
  - mem_stall=1.
- WAIT:
  - mem_stall=1; resp_valid is sampled only in this state.
  - On resp_valid: capture the extended load data (0 for stores); next state is DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, mem_timeout is pulsed in the next cycle, mem_rdata=0 and next state is DONE.
- DONE:
  - mem_stall=0; mem_done=1 with mem_rdata valid, except after a misalign pulse, where mem_done was already given.
  - The pipeline advances exactly one instruction on this edge. The next state is unconditionally IDLE, so the same instruction is never reissued.
- Store lanes:
  - B: strb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: strb = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: strb = 1111.
- Load extraction: the byte or half selected by addr[1:0] is sign-extended for 000/001 and zero-extended for 100/101.
- Memory ordering:
  - A resp_valid in IDLE, REQ or DONE is ignored (stray or late response).
  - The memory must not respond on the acceptance edge itself.
- Back-to-back accesses: there is a minimum of 1 idle-evaluation cycle between accesses (DONE→IDLE). Consecutive loads each cost ≥ 4 cycles.
- Reset mid-access: the FSM abandons to IDLE. The memory's in-flight response is then discarded by the stray-response rule.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - FSM state typedef;
  - 4-bit strobe type.
- One natural sub-module, mem_lane_align: combinational. It holds store-lane replication, strobe generation, load extraction/extension and legality check, so it can be unit-tested separately.

Test Plan:
- LW at 0x100, req_ready=1 immediately, resp_valid 2 cycles later with 0xDEADBEEF:
  - mem_stall high from the IDLE cycle through WAIT;
  - DONE cycle has mem_done=1, mem_rdata=0xDEADBEEF and mem_stall=0.
- LB at 0x103 with resp_rdata=0x80FF_0000 → mem_rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SH at 0x202, wdata=0x1234ABCD → req_strb=1100, req_wdata=0xABCDABCD, req_addr=0x200, req_we=1. The ack leads to mem_done with mem_rdata=0.
- LW at 0x101 → no req_valid ever; mem_misalign=1 and mem_done=1 in the same cycle with mem_stall=0. funct3=011 behaves identically.
- TIMEOUT_CYCLES=4 and resp_valid never asserted:
  - mem_timeout pulses once after 4 WAIT cycles, then DONE → IDLE.
  - A later resp_valid in IDLE has no effect.
- rst_n pulled low during WAIT → all outputs 0 asynchronously. After release, a new LW completes normally, and a stale resp_valid before the new request is ignored.
